alu_sequencer: RTL and testbench

Fetch/decode/execute control stage directly upstream of the 4-bit ALU. It fetches 12-bit instructions from a synchronous program ROM and holds a 4×4-bit register file. It drives the ALU `opCode`, `a` and `b` inputs, then writes `aOut` and `overFlow` back. It also handles load-immediate, branch-on-overflow and halt, so the ALU runs real programs instead of exhaustive bench sweeps.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/reg_file_4x4.sv | 34 +++
 rtl/alu_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and decode helpers for the ALU sequencer
package cpu_pkg;

  localparam int CPU_PC_W    = 8;
  localparam int CPU_INSTR_W = 12;

  // FSM encoding, kept as plain constants for compatibility with older blocks
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;

  // instruction classes in IR[11:10]
  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_LDI = 2'b01;
  localparam logic [1:0] CLS_BOV = 2'b10;
  localparam logic [1:0] CLS_HLT = 2'b11;

  // field positions
  localparam int CLS_HI = 11;
  localparam int CLS_LO = 10;
  localparam int OP_HI  = 9;
  localparam int OP_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS_HI  = 3;
  localparam int RS_LO  = 2;
  localparam int IMM_HI = 3;
  localparam int TGT_HI = 7;

  function automatic logic [1:0] instrClass(input logic [CPU_INSTR_W-1:0] word);
    return word[CLS_HI:CLS_LO];
  endfunction

endpackage

// File: rtl/reg_file_4x4.sv
// rtl/reg_file_4x4.sv - four 4-bit registers, two read ports, debug read, one write
module reg_file_4x4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rdAddrA,
  output logic [3:0] rdDataA,
  input  logic [1:0] rdAddrB,
  output logic [3:0] rdDataB,
  input  logic [1:0] dbgAddr,
  output logic [3:0] dbgData,
  input  logic       wrEn,
  input  logic [1:0] wrAddr,
  input  logic [3:0] wrData
);

  logic [3:0] regs [4];

  // reads are combinational so a read of the written register sees the old value
  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];
  assign dbgData = regs[dbgAddr];

  // single write port; reset clears every register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 4'd0;
      end
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute/writeback control in front of the 4-bit ALU
module alu_sequencer #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         opCode,
  output logic [3:0]         a,
  output logic [3:0]         b,
  input  logic [3:0]         aOut,
  input  logic               overFlow,
  output logic               ovfFlag,
  output logic               busy,
  output logic               halted,
  input  logic [1:0]         regSel,
  output logic [3:0]         regData
);

  import cpu_pkg::*;

  logic [2:0]         state;
  logic [PC_W-1:0]    pcReg;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         resVal;
  logic               resOvf;
  logic               ovfReg;

  logic [1:0]         irCls;
  logic               wrEn;
  logic [3:0]         wrData;
  logic               branchTaken;
  logic [PC_W-1:0]    branchTarget;

  assign irCls        = instrClass(ir);
  assign branchTaken  = (irCls == CLS_BOV) && ovfReg;
  assign branchTarget = PC_W'(ir[TGT_HI:0]);

  // register write happens only in writeback, from the captured ALU result or the immediate
  always_comb begin
    wrEn   = 1'b0;
    wrData = resVal;
    if (state == ST_WRITEBACK) begin
      if (irCls == CLS_ALU) begin
        wrEn   = 1'b1;
        wrData = resVal;
      end else if (irCls == CLS_LDI) begin
        wrEn   = 1'b1;
        wrData = ir[IMM_HI:0];
      end
    end
  end

  reg_file_4x4 u_regs (
    .clk     (clk),
    .reset   (reset),
    .rdAddrA (ir[RD_HI:RD_LO]),
    .rdDataA (a),
    .rdAddrB (ir[RS_HI:RS_LO]),
    .rdDataB (b),
    .dbgAddr (regSel),
    .dbgData (regData),
    .wrEn    (wrEn),
    .wrAddr  (ir[RD_HI:RD_LO]),
    .wrData  (wrData)
  );

  // sequencer FSM with pc, IR, result capture and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      pcReg  <= '0;
      ir     <= '0;
      resVal <= 4'd0;
      resOvf <= 1'b0;
      ovfReg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state <= ST_FETCH;
            pcReg <= '0;
          end
        end
        ST_FETCH: begin
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          ir    <= instr;
          state <= (instrClass(instr) == CLS_HLT) ? ST_HALT : ST_EXECUTE;
        end
        ST_EXECUTE: begin
          resVal <= aOut;
          resOvf <= overFlow;
          state  <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (irCls == CLS_ALU) begin
            ovfReg <= resOvf;
          end
          pcReg <= branchTaken ? branchTarget : pcReg + PC_W'(1);
          state <= ST_FETCH;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc      = pcReg;
  assign opCode  = ir[OP_HI:OP_LO];
  assign ovfFlag = ovfReg;
  assign busy    = (state == ST_FETCH) || (state == ST_DECODE) ||
                   (state == ST_EXECUTE) || (state == ST_WRITEBACK);
  assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench with ROM, stub ALU and ISA-level model
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pc;
  logic [11:0] instr;
  logic [3:0]  opCode;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [3:0]  aOut;
  logic        overFlow;
  logic        ovfFlag;
  logic        busy;
  logic        halted;
  logic [1:0]  regSel;
  logic [3:0]  regData;

  int nChecks = 0;
  int nPass   = 0;

  logic [11:0] rom [256];
  logic [3:0]  dutR [4];
  logic [3:0]  mR [4];
  logic        mFlag;
  logic [7:0]  mPc;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(8), .INSTR_W(12)) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
    .opCode(opCode), .a(a), .b(b), .aOut(aOut), .overFlow(overFlow),
    .ovfFlag(ovfFlag), .busy(busy), .halted(halted),
    .regSel(regSel), .regData(regData)
  );

  // stub ALU: 1 add (carry out), 2 sub (borrow), 3 and, everything else xor
  function automatic logic [4:0] stubAlu(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    case (op)
      4'h1:    return {1'b0, x} + {1'b0, y};
      4'h2:    return {1'b0, x} - {1'b0, y};
      4'h3:    return {1'b0, x & y};
      default: return {1'b0, x ^ y};
    endcase
  endfunction

  always_comb {overFlow, aOut} = stubAlu(opCode, a, b);

  // synchronous program ROM
  always @(posedge clk) instr <= rom[pc];

  function automatic logic [11:0] mkLdi(input logic [1:0] rd, input logic [3:0] imm);
    return {2'b01, 4'h0, rd, imm};
  endfunction
  function automatic logic [11:0] mkAlu(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs);
    return {2'b00, op, rd, rs, 2'b00};
  endfunction
  function automatic logic [11:0] mkBov(input logic [7:0] tgt);
    return {2'b10, 2'b00, tgt};
  endfunction
  function automatic logic [11:0] mkHlt();
    return 12'hC00;
  endfunction

  task automatic fillRom(input logic [11:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic readRegs();
    for (int i = 0; i < 4; i++) begin
      regSel = 2'(i);
      #1;
      dutR[i] = regData;
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mR[i] = 4'd0;
    mFlag = 1'b0;
    mPc   = 8'd0;
  endtask

  // instruction-level interpreter; n counts executed non-halt instructions
  task automatic modelRun(output int n);
    logic [11:0] w;
    logic [4:0]  r;
    mPc = 8'd0;
    n = 0;
    for (int step = 0; step < 4000; step++) begin
      w = rom[mPc];
      if (w[11:10] == 2'b11) break;
      n++;
      if (w[11:10] == 2'b00) begin
        r = stubAlu(w[9:6], mR[w[5:4]], mR[w[3:2]]);
        mR[w[5:4]] = r[3:0];
        mFlag = r[4];
        mPc = mPc + 8'd1;
      end else if (w[11:10] == 2'b01) begin
        mR[w[5:4]] = w[3:0];
        mPc = mPc + 8'd1;
      end else begin
        mPc = mFlag ? w[7:0] : mPc + 8'd1;
      end
    end
  endtask

  // start the program and count cycles until halted (cycle 1 = first cycle after start is sampled)
  task automatic runDut(output int cycles, output int busyBad, output bit sawWrap);
    logic [7:0] prevPc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 1;
    busyBad = 0;
    sawWrap = 1'b0;
    prevPc = pc;
    while (halted !== 1'b1 && cycles < 3000) begin
      if (busy !== 1'b1) busyBad++;
      @(posedge clk);
      #1;
      cycles++;
      if (prevPc == 8'hFF && pc == 8'h00) sawWrap = 1'b1;
      prevPc = pc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    regSel = 2'd0;
    fillRom(mkHlt());
    @(posedge clk);
    @(posedge clk);
    #1;
    nChecks++; if ({busy, halted} !== 2'b00) $display("FAIL reset_status got busy=%b halted=%b want 0 0", busy, halted); else nPass++;
    nChecks++; if ({pc, opCode, a, b} !== 20'h0) $display("FAIL reset_outputs got pc=%0h op=%0h a=%0h b=%0h want 0", pc, opCode, a, b); else nPass++;
    nChecks++; if ({ovfFlag, regData} !== 5'h0) $display("FAIL reset_flag_reg got ovf=%b regData=%0h want 0", ovfFlag, regData); else nPass++;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (busy !== 1'b0 || pc !== 8'h0) $display("FAIL idle_without_start got busy=%b pc=%0h want 0 0", busy, pc); else nPass++;
  endtask

  task automatic test_halt_only();
    int cyc, bb;
    bit wr;
    doReset();
    fillRom(mkHlt());
    runDut(cyc, bb, wr);
    readRegs();
    nChecks++; if (cyc !== 3 || halted !== 1'b1) $display("FAIL halt_latency got cycle=%0d halted=%b want 3 1", cyc, halted); else nPass++;
    nChecks++; if (bb !== 0) $display("FAIL halt_busy got %0d idle cycles want 0", bb); else nPass++;
    nChecks++; if (pc !== 8'h0 || busy !== 1'b0) $display("FAIL halt_pc got pc=%0h busy=%b want 0 0", pc, busy); else nPass++;
    nChecks++; if ({dutR[0], dutR[1], dutR[2], dutR[3]} !== 16'h0) $display("FAIL halt_regs got %0h want 0", {dutR[0], dutR[1], dutR[2], dutR[3]}); else nPass++;
  endtask

  task automatic test_add();
    int cyc, bb;
    bit wr;
    doReset();
    fillRom(mkHlt());
    rom[0] = mkLdi(2'd0, 4'd5);
    rom[1] = mkLdi(2'd1, 4'd3);
    rom[2] = mkAlu(4'h1, 2'd0, 2'd1);
    runDut(cyc, bb, wr);
    readRegs();
    nChecks++; if (dutR[0] !== 4'd8 || dutR[1] !== 4'd3) $display("FAIL add_result got R0=%0h R1=%0h want 8 3", dutR[0], dutR[1]); else nPass++;
    nChecks++; if (ovfFlag !== 1'b0) $display("FAIL add_flag got %b want 0", ovfFlag); else nPass++;
    nChecks++; if (cyc !== 15 || bb !== 0 || pc !== 8'd3) $display("FAIL add_timing got cycle=%0d idle=%0d pc=%0h want 15 0 3", cyc, bb, pc); else nPass++;
  endtask

  task automatic test_bov_taken();
    int cyc, bb;
    bit wr;
    doReset();
    fillRom(mkHlt());
    rom[0] = mkLdi(2'd0, 4'd9);
    rom[1] = mkLdi(2'd1, 4'd9);
    rom[2] = mkAlu(4'h1, 2'd0, 2'd1);
    rom[3] = mkBov(8'h10);
    runDut(cyc, bb, wr);
    readRegs();
    nChecks++; if (dutR[0] !== 4'd2 || ovfFlag !== 1'b1) $display("FAIL bov_taken_data got R0=%0h ovf=%b want 2 1", dutR[0], ovfFlag); else nPass++;
    nChecks++; if (pc !== 8'h10 || cyc !== 19 || halted !== 1'b1) $display("FAIL bov_taken_pc got pc=%0h cycle=%0d want 10 19", pc, cyc); else nPass++;
  endtask

  task automatic test_bov_fallthrough();
    int cyc, bb;
    bit wr;
    doReset();
    fillRom(mkHlt());
    rom[0] = mkLdi(2'd0, 4'd9);
    rom[1] = mkLdi(2'd1, 4'd1);
    rom[2] = mkAlu(4'h1, 2'd0, 2'd1);
    rom[3] = mkBov(8'h10);
    runDut(cyc, bb, wr);
    readRegs();
    nChecks++; if (dutR[0] !== 4'hA || ovfFlag !== 1'b0) $display("FAIL bov_fall_data got R0=%0h ovf=%b want a 0", dutR[0], ovfFlag); else nPass++;
    nChecks++; if (pc !== 8'h04 || cyc !== 19 || halted !== 1'b1) $display("FAIL bov_fall_pc got pc=%0h cycle=%0d want 4 19", pc, cyc); else nPass++;
  endtask

  task automatic test_same_reg_and_reset();
    int cyc;
    doReset();
    fillRom(mkHlt());
    rom[0] = mkLdi(2'd2, 4'd4);
    rom[1] = mkAlu(4'h1, 2'd2, 2'd2);
    rom[2] = mkAlu(4'h1, 2'd2, 2'd0);
    regSel = 2'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 11) begin
      if (cyc == 8) begin
        nChecks++; if (regData !== 4'd4) $display("FAIL rdrs_during_wb got %0h want 4", regData); else nPass++;
      end
      if (cyc == 9) begin
        nChecks++; if (regData !== 4'd8) $display("FAIL rdrs_after_wb got %0h want 8", regData); else nPass++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    nChecks++; if ({opCode, a, b} !== 12'h180) $display("FAIL execute_inputs got op=%0h a=%0h b=%0h want 1 8 0", opCode, a, b); else nPass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    nChecks++; if ({busy, halted, pc} !== 10'h0 || regData !== 4'd0 || ovfFlag !== 1'b0) $display("FAIL reset_mid_exec got busy=%b halted=%b pc=%0h R2=%0h", busy, halted, pc, regData); else nPass++;
    reset = 1'b0;
    @(posedge clk);
    #1;
    nChecks++; if (regData !== 4'd0 || busy !== 1'b0) $display("FAIL post_reset_nowrite got R2=%0h busy=%b want 0 0", regData, busy); else nPass++;
  endtask

  task automatic test_pc_wrap();
    int cyc, bb, n;
    bit wr;
    doReset();
    modelReset();
    fillRom(mkHlt());
    rom[0] = mkLdi(2'd0, 4'd9);
    rom[1] = mkAlu(4'h1, 2'd0, 2'd0);
    modelRun(n);
    runDut(cyc, bb, wr);
    nChecks++; if (ovfFlag !== 1'b1 || halted !== 1'b1) $display("FAIL wrap_setup got ovf=%b halted=%b want 1 1", ovfFlag, halted); else nPass++;
    fillRom(mkLdi(2'd3, 4'd0));
    rom[0]    = mkBov(8'hFD);
    rom[1]    = mkHlt();
    rom[8'hFF] = mkAlu(4'h1, 2'd3, 2'd3);
    modelRun(n);
    runDut(cyc, bb, wr);
    readRegs();
    nChecks++; if (wr !== 1'b1) $display("FAIL pc_wrap got wrap_seen=%b want 1", wr); else nPass++;
    nChecks++; if (pc !== mPc || cyc !== 4 * n + 3) $display("FAIL wrap_end got pc=%0h cycle=%0d want %0h %0d", pc, cyc, mPc, 4 * n + 3); else nPass++;
    nChecks++; if (dutR[0] !== mR[0] || ovfFlag !== mFlag) $display("FAIL wrap_state got R0=%0h ovf=%b want %0h %b", dutR[0], ovfFlag, mR[0], mFlag); else nPass++;
  endtask

  task automatic test_random();
    int cyc, bb, n, len;
    bit wr;
    logic [11:0] w;
    for (int p = 0; p < 8; p++) begin
      doReset();
      modelReset();
      fillRom(mkHlt());
      len = int'($urandom_range(3, 14));
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 4))
          0, 1: w = mkLdi(2'($urandom), 4'($urandom));
          2, 3: w = mkAlu(4'($urandom_range(0, 5)), 2'($urandom), 2'($urandom));
          default: w = mkBov(8'($urandom_range(i + 1, len)));
        endcase
        rom[i] = w;
      end
      modelRun(n);
      runDut(cyc, bb, wr);
      readRegs();
      nChecks++; if (halted !== 1'b1 || cyc !== 4 * n + 3) $display("FAIL rand%0d_latency got halted=%b cycle=%0d want 1 %0d", p, halted, cyc, 4 * n + 3); else nPass++;
      nChecks++; if (bb !== 0) $display("FAIL rand%0d_busy got %0d idle cycles want 0", p, bb); else nPass++;
      nChecks++; if (pc !== mPc || ovfFlag !== mFlag) $display("FAIL rand%0d_pcflag got pc=%0h ovf=%b want %0h %b", p, pc, ovfFlag, mPc, mFlag); else nPass++;
      for (int r = 0; r < 4; r++) begin
        nChecks++; if (dutR[r] !== mR[r]) $display("FAIL rand%0d_R%0d got %0h want %0h", p, r, dutR[r], mR[r]); else nPass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    regSel = 2'd0;
    test_reset();
    test_halt_only();
    test_add();
    test_bov_taken();
    test_bov_fallthrough();
    test_same_reg_and_reset();
    test_pc_wrap();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
